axis_fifo_buffer: RTL and testbench

Parametrised AXI-Stream elastic buffer. It generalises the 2-entry skid buffer to DEPTH entries, adds a working flush and an occupancy output, and removes every combinational path from m-side tready to s-side tready. It is placed between pipeline stages (fetch/decode, LSU response) where bursts must be absorbed and a redirect must discard all in-flight beats.

---
 rtl/axis_buffer_pkg.sv | 26 ++
 rtl/axis_if.sv | 16 +
 rtl/axis_fifo_buffer.sv | 128 ++++++++++++
 tb/tb_axis_fifo_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_buffer_pkg.sv
// ---------------------------------------------------------------------------
// axis_buffer_pkg
// Shared sizing helpers for the axis_* family of stream buffers.
//   ptr_width(depth)   : bits needed to index 'depth' storage entries
//   count_width(depth) : bits needed to hold an occupancy of 0..depth
//   is_pow2(depth)     : legal depth check (power of two, at least 2)
// ---------------------------------------------------------------------------
package axis_buffer_pkg;

   // Index width for a circular buffer of 'depth' entries.  Clamped to one
   // bit so that an illegal depth still elaborates far enough to report it.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy needs one more state than there are entries (empty .. full).
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Pointers wrap by natural overflow, which only works for powers of two.
   function automatic bit is_pow2(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/axis_if.sv
// ---------------------------------------------------------------------------
// axis_if
// Minimal AXI-Stream bundle (tvalid/tready/tdata).
//   m : manager view  (drives tvalid/tdata, receives tready)
//   s : subordinate view (receives tvalid/tdata, drives tready)
// ---------------------------------------------------------------------------
interface axis_if #(
   parameter int TDATA_WIDTH = 32
) ();
   logic                   tvalid;
   logic                   tready;
   logic [TDATA_WIDTH-1:0] tdata;

   modport m (output tvalid, output tdata, input tready);
   modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_fifo_buffer.sv
// ---------------------------------------------------------------------------
// axis_fifo_buffer
// DEPTH-entry AXI-Stream elastic buffer with flush and occupancy output.
// Both handshake outputs are decoded from the registered occupancy only, so
// there is no combinational path from downstream tready to upstream tready,
// and an empty buffer never bypasses an incoming beat to the output.
//
// Ports:
//   clk      : clock
//   rst      : synchronous, active-high reset
//   axis_sif : upstream subordinate (tvalid/tready/tdata)
//   axis_mif : downstream manager   (tvalid/tready/tdata), same data width
//   flush    : discard every stored beat; blocks both handshakes this cycle
//   count    : registered occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module axis_fifo_buffer
   import axis_buffer_pkg::*;
#(
   parameter  int DEPTH       = 4,
   localparam int COUNT_WIDTH = count_width(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   axis_if.s                      axis_sif,
   axis_if.m                      axis_mif,
   input  logic                   flush,
   output logic [COUNT_WIDTH-1:0] count
);

   localparam int TDATA_WIDTH = $bits(axis_sif.tdata);
   localparam int PTR_WIDTH   = ptr_width(DEPTH);

   // ------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------
   generate
      if (!is_pow2(DEPTH)) begin : g_bad_depth
         $fatal(1, "axis_fifo_buffer: DEPTH must be a power of two >= 2");
      end
      if ($bits(axis_mif.tdata) != TDATA_WIDTH) begin : g_bad_width
         $fatal(1, "axis_fifo_buffer: axis_sif and axis_mif TDATA_WIDTH differ");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------
   logic [TDATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH-1:0]   wr_ptr;
   logic [PTR_WIDTH-1:0]   rd_ptr;
   logic [COUNT_WIDTH-1:0] cnt;

   logic s_ready;
   logic m_valid;
   logic s_hs;
   logic m_hs;

   // Ready/valid come from cnt alone.  rst is folded in so the outputs read
   // 0 during the reset cycles even before cnt has been cleared; flush gates
   // both sides so no beat can move in a flush cycle.
   assign s_ready = !rst && !flush && (cnt != COUNT_WIDTH'(DEPTH));
   assign m_valid = !rst && !flush && (cnt != '0);

   assign s_hs = axis_sif.tvalid && s_ready;
   assign m_hs = m_valid && axis_mif.tready;

   assign axis_sif.tready = s_ready;
   assign axis_mif.tvalid = m_valid;
   assign axis_mif.tdata  = mem[rd_ptr];

   // Report 0 while reset is held, even in the first reset cycle.
   assign count = rst ? '0 : cnt;

   // ------------------------------------------------------------------
   // Storage, pointers and occupancy
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // s_hs is already 0 under rst/flush or when full, so a live entry is
      // never overwritten and the array itself needs no reset.
      if (s_hs) begin
         mem[wr_ptr] <= axis_sif.tdata;
      end

      if (rst) begin
         cnt    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         // Dropping everything is just catching the read side up.
         cnt    <= '0;
         rd_ptr <= wr_ptr;
      end else begin
         if (s_hs) begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         end
         if (m_hs) begin
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         end
         case ({s_hs, m_hs})
            2'b10:   cnt <= cnt + COUNT_WIDTH'(1);
            2'b01:   cnt <= cnt - COUNT_WIDTH'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Protocol checks (simulation only)
   // ------------------------------------------------------------------
`ifndef SYNTHESIS
   // Upstream must hold a refused beat; a flush or reset discards it anyway.
   a_s_hold : assert property (@(posedge clk)
      (axis_sif.tvalid && !s_ready && !flush && !rst)
      |=> (rst || flush || (axis_sif.tvalid && $stable(axis_sif.tdata))))
      else $error("axis_fifo_buffer: upstream dropped or changed a stalled beat");

   // Offered output beat stays put until taken, flushed or reset.
   a_m_hold : assert property (@(posedge clk)
      (m_valid && !axis_mif.tready)
      |=> (rst || flush || (m_valid && $stable(axis_mif.tdata))))
      else $error("axis_fifo_buffer: output beat withdrawn or changed while stalled");

   a_cnt_range : assert property (@(posedge clk)
      rst || (cnt <= COUNT_WIDTH'(DEPTH)))
      else $error("axis_fifo_buffer: occupancy exceeds DEPTH");
`endif

endmodule

// File: tb/tb_axis_fifo_buffer.sv
// ---------------------------------------------------------------------------
// tb_axis_fifo_buffer
// Directed bench for axis_fifo_buffer (DEPTH=4, 32-bit data).  A queue model
// of the buffer predicts ready/valid/data/count every cycle; directed phases
// add literal expectations and a final check of the full output sequence.
// ---------------------------------------------------------------------------
module tb_axis_fifo_buffer;

   localparam int DEPTH = 4;
   localparam int W     = 32;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       flush = 1'b0;
   logic [2:0] count;

   axis_if #(.TDATA_WIDTH(W)) s_if ();
   axis_if #(.TDATA_WIDTH(W)) m_if ();

   always #5 clk = ~clk;

   axis_fifo_buffer #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .axis_sif (s_if),
      .axis_mif (m_if),
      .flush    (flush),
      .count    (count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] model_q [$];
   logic [W-1:0] out_log [$];
   logic [W-1:0] exp_log [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- queue model: state advances on each clock edge -----
   logic mdl_push, mdl_pop;
   always @(posedge clk) begin
      if (rst || flush) begin
         model_q.delete();
      end else begin
         mdl_pop  = m_if.tready && (model_q.size() > 0);
         mdl_push = s_if.tvalid && (model_q.size() < DEPTH);
         if (mdl_pop) void'(model_q.pop_front());
         if (mdl_push) model_q.push_back(s_if.tdata);
      end
   end

   // ---------------- per-cycle compare on the falling edge --------------
   logic exp_rdy, exp_vld;
   int   exp_cnt;
   always @(negedge clk) begin
      exp_rdy = !rst && !flush && (model_q.size() < DEPTH);
      exp_vld = !rst && !flush && (model_q.size() > 0);
      exp_cnt = rst ? 0 : model_q.size();
      chk("mdl_s_tready", 32'(s_if.tready), 32'(exp_rdy));
      chk("mdl_m_tvalid", 32'(m_if.tvalid), 32'(exp_vld));
      chk("mdl_count", 32'(count), 32'(exp_cnt));
      if (exp_vld) chk("mdl_m_tdata", m_if.tdata, model_q[0]);
      if (m_if.tvalid && m_if.tready) out_log.push_back(m_if.tdata);
   end

   // ---------------- stimulus helpers -----------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   logic [W-1:0] sv [4];

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      m_if.tready = 1'b0;

      // ---- reset held two cycles ----
      for (int i = 0; i < 2; i++) begin
         at_neg();
         chk("rst_tready", 32'(s_if.tready), 0);
         chk("rst_tvalid", 32'(m_if.tvalid), 0);
         chk("rst_count", 32'(count), 0);
         step();
      end
      rst = 1'b0;
      at_neg();
      chk("post_rst_tready", 32'(s_if.tready), 1);
      chk("post_rst_tvalid", 32'(m_if.tvalid), 0);
      chk("post_rst_count", 32'(count), 0);
      step();

      // ---- streaming through an empty buffer ----
      sv[0] = 32'h11; sv[1] = 32'h22; sv[2] = 32'h33; sv[3] = 32'h44;
      m_if.tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = sv[i];
         at_neg();
         chk("stream_count", 32'(count), (i == 0) ? 0 : 1);
         if (i == 0) chk("stream_no_bypass", 32'(m_if.tvalid), 0);
         else        chk("stream_tdata", m_if.tdata, sv[i-1]);
         step();
         exp_log.push_back(sv[i]);
      end
      s_if.tvalid = 1'b0;
      at_neg();
      chk("stream_last", m_if.tdata, 32'h44);
      chk("stream_last_count", 32'(count), 1);
      step();
      at_neg();
      chk("stream_empty", 32'(count), 0);
      step();

      // ---- fill to full under backpressure, then drain ----
      m_if.tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = 32'hA0 + 32'(i);
         at_neg();
         chk("fill_tready", 32'(s_if.tready), (i < 4) ? 1 : 0);
         step();
      end
      m_if.tready = 1'b1;
      at_neg();
      chk("full_count", 32'(count), 4);
      chk("full_tready", 32'(s_if.tready), 0);
      chk("full_head", m_if.tdata, 32'hA0);
      step();
      at_neg();
      chk("after_drain_tready", 32'(s_if.tready), 1);
      chk("after_drain_count", 32'(count), 3);
      chk("after_drain_head", m_if.tdata, 32'hA1);
      step();
      s_if.tvalid = 1'b0;
      for (int k = 2; k < 5; k++) begin
         at_neg();
         chk("drain_tdata", m_if.tdata, 32'hA0 + 32'(k));
         step();
      end
      for (int k = 0; k < 5; k++) exp_log.push_back(32'hA0 + 32'(k));

      // ---- simultaneous push/pop at full, continuous stream across wraps ----
      m_if.tready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = 32'hB0 + 32'(i);
         at_neg();
         step();
      end
      s_if.tdata  = 32'hB4;
      m_if.tready = 1'b1;
      at_neg();
      chk("pp_full_count", 32'(count), 4);
      chk("pp_full_tready", 32'(s_if.tready), 0);
      step();
      at_neg();
      chk("pp_next_tready", 32'(s_if.tready), 1);
      chk("pp_next_count", 32'(count), 3);
      chk("pp_next_head", m_if.tdata, 32'hB1);
      step();
      for (int j = 5; j < 15; j++) begin
         s_if.tdata = 32'hB0 + 32'(j);
         at_neg();
         chk("pp_steady_count", 32'(count), 3);
         step();
      end
      s_if.tvalid = 1'b0;
      for (int k = 12; k < 15; k++) begin
         at_neg();
         chk("pp_drain_tdata", m_if.tdata, 32'hB0 + 32'(k));
         step();
      end
      for (int k = 0; k < 15; k++) exp_log.push_back(32'hB0 + 32'(k));

      // ---- flush mid-stream (held two cycles) ----
      m_if.tready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = 32'hC0 + 32'(i);
         at_neg();
         step();
      end
      flush       = 1'b1;
      s_if.tdata  = 32'hDEAD;
      at_neg();
      chk("flush_tready", 32'(s_if.tready), 0);
      chk("flush_tvalid", 32'(m_if.tvalid), 0);
      step();
      at_neg();
      chk("flush2_tready", 32'(s_if.tready), 0);
      chk("flush2_count", 32'(count), 0);
      step();
      flush       = 1'b0;
      s_if.tvalid = 1'b0;
      at_neg();
      chk("post_flush_count", 32'(count), 0);
      chk("post_flush_tvalid", 32'(m_if.tvalid), 0);
      step();
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'hBEEF;
      m_if.tready = 1'b1;
      at_neg();
      chk("beef_accept", 32'(s_if.tready), 1);
      chk("beef_no_bypass", 32'(m_if.tvalid), 0);
      step();
      s_if.tvalid = 1'b0;
      at_neg();
      chk("beef_out_valid", 32'(m_if.tvalid), 1);
      chk("beef_out_data", m_if.tdata, 32'hBEEF);
      step();
      exp_log.push_back(32'hBEEF);

      // ---- reset mid-operation with output stalled ----
      m_if.tready = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = 32'hD0 + 32'(i);
         at_neg();
         step();
      end
      s_if.tvalid = 1'b0;
      at_neg();
      chk("pre_rst_count", 32'(count), 2);
      chk("pre_rst_head", m_if.tdata, 32'hD1);
      step();
      rst = 1'b1;
      at_neg();
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_tvalid", 32'(m_if.tvalid), 0);
      step();
      rst = 1'b0;
      at_neg();
      chk("after_rst_count", 32'(count), 0);
      chk("after_rst_tvalid", 32'(m_if.tvalid), 0);
      step();
      m_if.tready = 1'b1;
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'hE1;
      at_neg();
      step();
      s_if.tvalid = 1'b0;
      at_neg();
      chk("after_rst_data", m_if.tdata, 32'hE1);
      step();
      at_neg();
      step();
      exp_log.push_back(32'hE1);

      // ---- full output sequence: order kept, flushed/reset beats absent ----
      chk("out_log_len", 32'(out_log.size()), 32'(exp_log.size()));
      for (int i = 0; i < exp_log.size(); i++) begin
         if (i < out_log.size()) chk("out_log_beat", out_log[i], exp_log[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
